// File: rtl/vga_char_scanner.sv
// 640x480@60Hz raster scanner: drives the character buffer read address from the
// h/v counters and turns the buffer's lit/out-of-bounds reply into registered VGA pins.
module vga_char_scanner #(
    parameter int          P_H_ACTIVE   = 640,
    parameter int          P_H_FP       = 16,
    parameter int          P_H_SYNC     = 96,
    parameter int          P_H_BP       = 48,
    parameter int          P_V_ACTIVE   = 480,
    parameter int          P_V_FP       = 10,
    parameter int          P_V_SYNC     = 2,
    parameter int          P_V_BP       = 33,
    parameter int          P_SCALE_LOG2 = 0,
    parameter logic [11:0] P_FG_RGB     = 12'hFFF,
    parameter logic [11:0] P_BG_RGB     = 12'h000,
    parameter logic [11:0] P_OOB_RGB    = 12'h004
) (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] read_hchar,
    output logic [5:0] read_vchar,
    output logic [2:0] read_hoffset,
    output logic [2:0] read_voffset,
    input  logic       read_lit,
    input  logic       out_of_bounds,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_start
);

    localparam logic [9:0] H_ACT    = 10'(P_H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(P_H_ACTIVE + P_H_FP);
    localparam logic [9:0] HS_LAST  = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC - 1);
    localparam logic [9:0] V_ACT    = 10'(P_V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
    localparam logic [9:0] VS_FIRST = 10'(P_V_ACTIVE + P_V_FP);
    localparam logic [9:0] VS_LAST  = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC - 1);

    function automatic logic [11:0] pixel_colour(input logic active,
                                                 input logic oob,
                                                 input logic lit);
        logic [11:0] c;
        c = P_BG_RGB;
        if (!active) begin
            c = 12'h000;
        end else if (oob) begin
            c = P_OOB_RGB;
        end else if (lit) begin
            c = P_FG_RGB;
        end
        return c;
    endfunction

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        active;
    logic [9:0]  px, py;

    logic        s1_hs_n_q, s1_hs_n_d;
    logic        s1_vs_n_q, s1_vs_n_d;
    logic        s1_active_q, s1_active_d;
    logic        s1_first_q, s1_first_d;

    logic        vga_hs_q, vga_hs_d;
    logic        vga_vs_q, vga_vs_d;
    logic        frame_start_q, frame_start_d;
    logic [11:0] rgb_q, rgb_d;

    // Raster counters and combinational buffer address
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        px           = h_cnt_q >> P_SCALE_LOG2;
        py           = v_cnt_q >> P_SCALE_LOG2;
        read_hchar   = 7'd0;
        read_hoffset = 3'd0;
        read_vchar   = 6'd0;
        read_voffset = 3'd0;
        if (active) begin
            read_hchar   = 7'(px >> 3);
            read_hoffset = px[2:0];
            read_vchar   = 6'(py >> 3);
            read_voffset = py[2:0];
        end
    end

    // Stage 1: timing flags delayed to line up with the buffer's read latency
    always_comb begin
        s1_hs_n_d   = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        s1_vs_n_d   = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        s1_active_d = active;
        s1_first_d  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    // Stage 2: output registers; blanking overrides whatever the buffer returned
    always_comb begin
        vga_hs_d      = s1_hs_n_q;
        vga_vs_d      = s1_vs_n_q;
        frame_start_d = s1_first_q;
        rgb_d         = pixel_colour(s1_active_q, out_of_bounds, read_lit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            s1_hs_n_q     <= 1'b1;
            s1_vs_n_q     <= 1'b1;
            s1_active_q   <= 1'b0;
            s1_first_q    <= 1'b0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            frame_start_q <= 1'b0;
            rgb_q         <= 12'h000;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            s1_hs_n_q     <= s1_hs_n_d;
            s1_vs_n_q     <= s1_vs_n_d;
            s1_active_q   <= s1_active_d;
            s1_first_q    <= s1_first_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign frame_start = frame_start_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_char_scanner.sv
// Bench for vga_char_scanner: full-timing, 2x-scaled and reduced-timing instances
// share one clock, reset and buffer reply, each checked against a raster model.
module tb_vga_char_scanner;

    typedef struct packed {
        int ha; int hf; int hsy; int hb;
        int va; int vf; int vsy; int vb;
        int sc;
    } tim_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } pins_t;

    typedef struct packed {
        logic [6:0] hc;
        logic [5:0] vc;
        logic [2:0] ho;
        logic [2:0] vo;
    } addr_t;

    localparam tim_t T_FULL = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    localparam tim_t T_S1   = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    localparam tim_t T_SM   = '{16, 2, 4, 2, 8, 1, 2, 1, 0};
    localparam tim_t TIMS [3] = '{T_FULL, T_S1, T_SM};

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst;
    logic lit;
    logic oob;

    logic [6:0] hchar [3];
    logic [5:0] vchar [3];
    logic [2:0] hoff  [3];
    logic [2:0] voff  [3];
    logic       hs    [3];
    logic       vs    [3];
    logic [3:0] r     [3];
    logic [3:0] g     [3];
    logic [3:0] b     [3];
    logic       fs    [3];

    pins_t obs_pins [3];
    addr_t obs_addr [3];

    for (genvar k = 0; k < 3; k++) begin : g_obs
        assign obs_pins[k] = {hs[k], vs[k], fs[k], r[k], g[k], b[k]};
        assign obs_addr[k] = {hchar[k], vchar[k], hoff[k], voff[k]};
    end

    vga_char_scanner u_full (
        .clk(clk), .rst(rst),
        .read_hchar(hchar[0]), .read_vchar(vchar[0]),
        .read_hoffset(hoff[0]), .read_voffset(voff[0]),
        .read_lit(lit), .out_of_bounds(oob),
        .vga_hs(hs[0]), .vga_vs(vs[0]),
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]),
        .frame_start(fs[0])
    );

    vga_char_scanner #(.P_SCALE_LOG2(1)) u_s1 (
        .clk(clk), .rst(rst),
        .read_hchar(hchar[1]), .read_vchar(vchar[1]),
        .read_hoffset(hoff[1]), .read_voffset(voff[1]),
        .read_lit(lit), .out_of_bounds(oob),
        .vga_hs(hs[1]), .vga_vs(vs[1]),
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]),
        .frame_start(fs[1])
    );

    vga_char_scanner #(
        .P_H_ACTIVE(T_SM.ha), .P_H_FP(T_SM.hf), .P_H_SYNC(T_SM.hsy), .P_H_BP(T_SM.hb),
        .P_V_ACTIVE(T_SM.va), .P_V_FP(T_SM.vf), .P_V_SYNC(T_SM.vsy), .P_V_BP(T_SM.vb)
    ) u_sm (
        .clk(clk), .rst(rst),
        .read_hchar(hchar[2]), .read_vchar(vchar[2]),
        .read_hoffset(hoff[2]), .read_voffset(voff[2]),
        .read_lit(lit), .out_of_bounds(oob),
        .vga_hs(hs[2]), .vga_vs(vs[2]),
        .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]),
        .frame_start(fs[2])
    );

    int n;        // cycles since the raster last restarted at (0,0)
    int checks;
    int passes;

    // Pins in cycle n show the raster position of cycle n-2 and the buffer reply of cycle n-1.
    function automatic pins_t exp_pins(input int cyc, input tim_t t, input logic l, input logic o);
        pins_t p;
        int ht, vt, c, h, v;
        p  = {1'b1, 1'b1, 1'b0, 12'h000};
        ht = t.ha + t.hf + t.hsy + t.hb;
        vt = t.va + t.vf + t.vsy + t.vb;
        if (cyc >= 2) begin
            c     = cyc - 2;
            h     = c % ht;
            v     = (c / ht) % vt;
            p.hs  = !(h >= t.ha + t.hf && h < t.ha + t.hf + t.hsy);
            p.vs  = !(v >= t.va + t.vf && v < t.va + t.vf + t.vsy);
            p.fs  = (c % (ht * vt)) == 0;
            if (h < t.ha && v < t.va) p.rgb = o ? 12'h004 : (l ? 12'hFFF : 12'h000);
        end
        return p;
    endfunction

    function automatic addr_t exp_addr(input int cyc, input tim_t t);
        addr_t a;
        int ht, vt, h, v, px, py;
        a  = '0;
        ht = t.ha + t.hf + t.hsy + t.hb;
        vt = t.va + t.vf + t.vsy + t.vb;
        h  = cyc % ht;
        v  = (cyc / ht) % vt;
        if (h < t.ha && v < t.va) begin
            px   = h >> t.sc;
            py   = v >> t.sc;
            a.hc = 7'((px / 8) % 128);
            a.ho = 3'(px % 8);
            a.vc = 6'((py / 8) % 64);
            a.vo = 3'(py % 8);
        end
        return a;
    endfunction

    task automatic step(input logic l, input logic o);
        lit = l;
        oob = o;
        @(posedge clk);
        if (rst) n = 0;
        else     n = n + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_pins[i] !== {1'b1, 1'b1, 1'b0, 12'h000})
                    $display("FAIL reset_pins inst%0d got %h want %h", i, obs_pins[i], {1'b1, 1'b1, 1'b0, 12'h000});
                else passes++;
                checks++;
                if (obs_addr[i] !== exp_addr(n, TIMS[i]))
                    $display("FAIL reset_addr inst%0d got %h want %h", i, obs_addr[i], exp_addr(n, TIMS[i]));
                else passes++;
            end
        end
        rst = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if (fs[0] !== 1'b0) $display("FAIL release_fs_early got %b want 0", fs[0]);
        else passes++;
        step(1'b0, 1'b0);
        checks++;
        if (fs[0] !== 1'b1) $display("FAIL release_fs_2clk got %b want 1", fs[0]);
        else passes++;
    endtask

    // Buffer lights only the glyph pixel at hchar=3, hoffset=0 on line 0 and answers one clock late.
    task automatic test_pixel_path();
        int h, v;
        while (n < 802) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_pins[i] !== exp_pins(n, TIMS[i], lit, oob))
                    $display("FAIL pixel_path inst%0d n=%0d got %h want %h", i, n, obs_pins[i], exp_pins(n, TIMS[i], lit, oob));
                else passes++;
            end
            if (n >= 25 && n <= 27) begin
                checks++;
                if (obs_pins[0].rgb !== ((n == 26) ? 12'hFFF : 12'h000))
                    $display("FAIL lit_pixel n=%0d got %h want %h", n, obs_pins[0].rgb, (n == 26) ? 12'hFFF : 12'h000);
                else passes++;
            end
            h = (n - 1) % 800;
            v = ((n - 1) / 800) % 525;
            step((h == 24) && (v == 0), 1'b0);
        end
    endtask

    // read_lit held high all line, out_of_bounds random: blanking must still read 0.
    task automatic test_oob_blanking();
        while (n < 1602) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_pins[i] !== exp_pins(n, TIMS[i], lit, oob))
                    $display("FAIL oob_blank inst%0d n=%0d got %h want %h", i, n, obs_pins[i], exp_pins(n, TIMS[i], lit, oob));
                else passes++;
            end
            step(1'b1, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_line_timing();
        logic prev_hs;
        int   low_cnt, falls;
        prev_hs = obs_pins[0].hs;
        low_cnt = 0;
        falls   = 0;
        while (n < 4002) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_pins[i] !== exp_pins(n, TIMS[i], lit, oob))
                    $display("FAIL line_pins inst%0d n=%0d got %h want %h", i, n, obs_pins[i], exp_pins(n, TIMS[i], lit, oob));
                else passes++;
            end
            if (prev_hs && !obs_pins[0].hs) begin
                falls++;
                checks++;
                if ((n % 800) != 658) $display("FAIL hs_fall_pos got %0d want 658", n % 800);
                else passes++;
            end
            if (!obs_pins[0].hs) low_cnt++;
            if (((n - 2) % 800) == 799) begin
                checks++;
                if (low_cnt != 96) $display("FAIL hs_low_width got %0d want 96", low_cnt);
                else passes++;
                low_cnt = 0;
            end
            prev_hs = obs_pins[0].hs;
            step(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0));
        end
        checks++;
        if (falls != 3) $display("FAIL hs_fall_count got %0d want 3", falls);
        else passes++;
    endtask

    // Reduced-timing instance: 24x12 raster, so a frame is 288 clocks with vs low for 48.
    task automatic test_frame_timing();
        int start, pulses, last, vs_low;
        start  = n;
        pulses = 0;
        last   = 0;
        vs_low = 0;
        while (pulses < 4 && n < start + 1500) begin
            checks++;
            if (obs_pins[2].fs && pulses > 0 && obs_pins[2] === exp_pins(n, T_SM, lit, oob)) begin
                if ((n - last) != 288 || vs_low != 48)
                    $display("FAIL frame_period got %0d/%0d want 288/48", n - last, vs_low);
                else passes++;
            end else if (obs_pins[2] !== exp_pins(n, T_SM, lit, oob)) begin
                $display("FAIL frame_pins n=%0d got %h want %h", n, obs_pins[2], exp_pins(n, T_SM, lit, oob));
            end else passes++;
            checks++;
            if (obs_addr[2] !== exp_addr(n, T_SM))
                $display("FAIL frame_addr n=%0d got %h want %h", n, obs_addr[2], exp_addr(n, T_SM));
            else passes++;
            if (obs_pins[2].fs) begin
                pulses++;
                last   = n;
                vs_low = 0;
            end
            if (!obs_pins[2].vs) vs_low++;
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        checks++;
        if (pulses < 4) $display("FAIL frame_timeout got %0d pulses want 4", pulses);
        else passes++;
    endtask

    task automatic test_mapping();
        while (n <= 15235) begin
            if ($urandom_range(63, 0) == 0) begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs_addr[i] !== exp_addr(n, TIMS[i]))
                        $display("FAIL addr_spot inst%0d n=%0d got %h want %h", i, n, obs_addr[i], exp_addr(n, TIMS[i]));
                    else passes++;
                end
            end
            if (n == 7217) begin
                checks++;
                if (obs_addr[0] !== {7'd2, 6'd1, 3'd1, 3'd1})
                    $display("FAIL map_17_9 got %h want %h", obs_addr[0], {7'd2, 6'd1, 3'd1, 3'd1});
                else passes++;
            end
            if (n == 7900) begin
                checks++;
                if (obs_addr[0] !== 19'd0) $display("FAIL map_blank got %h want 0", obs_addr[0]);
                else passes++;
            end
            if (n == 15235) begin
                checks++;
                if (obs_addr[1] !== {7'd2, 6'd1, 3'd1, 3'd1})
                    $display("FAIL map_scale1 got %h want %h", obs_addr[1], {7'd2, 6'd1, 3'd1, 3'd1});
                else passes++;
            end
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic test_mid_reset();
        while (n < 16300) step(n >= 16290, 1'b0);
        checks++;
        if (obs_pins[0].rgb !== 12'hFFF) $display("FAIL pre_reset_rgb got %h want fff", obs_pins[0].rgb);
        else passes++;
        rst = 1'b1;
        step(1'b1, 1'b0);
        checks++;
        if (obs_addr[0] !== 19'd0) $display("FAIL mid_reset_addr got %h want 0", obs_addr[0]);
        else passes++;
        checks++;
        if (obs_pins[0] !== {1'b1, 1'b1, 1'b0, 12'h000})
            $display("FAIL mid_reset_pins got %h want %h", obs_pins[0], {1'b1, 1'b1, 1'b0, 12'h000});
        else passes++;
        rst = 1'b0;
        step(1'b1, 1'b0);
        while (n < 900) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_pins[i] !== exp_pins(n, TIMS[i], lit, oob) || obs_addr[i] !== exp_addr(n, TIMS[i]))
                    $display("FAIL restart inst%0d n=%0d got %h/%h want %h/%h", i, n, obs_pins[i], obs_addr[i], exp_pins(n, TIMS[i], lit, oob), exp_addr(n, TIMS[i]));
                else passes++;
            end
            step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        rst    = 1'b1;
        lit    = 1'b0;
        oob    = 1'b0;
        n      = 0;
        checks = 0;
        passes = 0;
        @(negedge clk);
        test_reset();
        test_pixel_path();
        test_oob_blanking();
        test_line_timing();
        test_frame_timing();
        test_mapping();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
